// File: rtl/pkt_rx_pkg.sv
// Shared constants, state encoding and sizing helper for the packet receive controller.
package pkt_rx_pkg;

  localparam int unsigned FRAME_W          = 64;
  localparam int unsigned DEF_SAMPLE_DIV   = 4;
  localparam int unsigned DEF_HUNT_TIMEOUT = 1024;
  localparam int unsigned DEF_HOLD_TIMEOUT = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HUNT   = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_HUNT   = ST_HUNT,
    S_HOLD   = ST_HOLD,
    S_FLUSH  = ST_FLUSH,
    S_SETTLE = ST_SETTLE
  } state_e;

  typedef logic [FRAME_W-1:0] frame_t;

  // Bits needed to hold values 0..max_val (never less than one).
  function automatic int unsigned timer_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pkt_rx_ctrl.sv
// Sequencer for the 64-bit serial shift buffer: sample strobe, frame capture,
// valid/ready hand-off, buffer clears and delivered/dropped frame counters.
module pkt_rx_ctrl
  import pkt_rx_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int unsigned HUNT_TIMEOUT = DEF_HUNT_TIMEOUT,
  parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_en,
  output logic               sb_rst_n,
  output logic               sb_en,
  output logic               sb_pkt_rst,
  input  logic [FRAME_W-1:0] sb_dout,
  input  logic               sb_pkt_rec,
  output logic [FRAME_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               hunt_to,
  output logic               busy
);

  localparam int unsigned DIV_W  = timer_w(SAMPLE_DIV);
  localparam int unsigned BIT_W  = timer_w(HUNT_TIMEOUT);
  localparam int unsigned HOLD_W = timer_w(HOLD_TIMEOUT);

  state_e            state, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sb_en_q;
  logic              valid_d;
  logic              capture;
  logic              hunt_to_d;
  logic              pkt_inc;
  logic              drop_inc;
  logic              div_last;
  logic              bit_expired;
  logic              hold_expired;

  assign sb_rst_n = ~rst;

  // The strobe is scheduled one clock ahead; a capture cycle suppresses it so
  // the buffer is never shifted on the edge that latches the frame.
  assign sb_en = sb_en_q & ~sb_pkt_rec;

  assign div_last     = (32'(div_q) == SAMPLE_DIV - 32'd1);
  assign bit_expired  = (HUNT_TIMEOUT != 0) && (32'(bit_q) == HUNT_TIMEOUT);
  assign hold_expired = (HOLD_TIMEOUT != 0) && (32'(hold_q) + 32'd1 == HOLD_TIMEOUT);

  // Next-state, timers and handshake decisions.
  always_comb begin
    state_d   = state;
    div_d     = div_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    valid_d   = out_valid;
    capture   = 1'b0;
    hunt_to_d = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_en) begin
          state_d = S_HUNT;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      S_HUNT: begin
        div_d = div_last ? '0 : div_q + DIV_W'(1);
        if (sb_en && (HUNT_TIMEOUT != 0)) begin
          bit_d = bit_q + BIT_W'(1);
        end
        if (sb_pkt_rec) begin
          capture = 1'b1;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = S_HOLD;
        end else if (bit_expired) begin
          hunt_to_d = 1'b1;
          state_d   = S_FLUSH;
        end else if (!rx_en) begin
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (HOLD_TIMEOUT != 0) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (out_ready) begin
          valid_d = 1'b0;
          pkt_inc = 1'b1;
          state_d = S_FLUSH;
        end else if (hold_expired) begin
          valid_d  = 1'b0;
          drop_inc = 1'b1;
          state_d  = S_FLUSH;
        end
      end

      S_FLUSH: begin
        state_d = S_SETTLE;
      end

      // The buffer flag is stale right after a clear, so it is not looked at here.
      S_SETTLE: begin
        if (rx_en) begin
          state_d = S_HUNT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      hold_q     <= '0;
      sb_en_q    <= 1'b0;
      sb_pkt_rst <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      hunt_to    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      hold_q     <= hold_d;
      sb_en_q    <= (state_d == S_HUNT) && (32'(div_d) == SAMPLE_DIV - 32'd1);
      sb_pkt_rst <= (state_d == S_FLUSH);
      out_valid  <= valid_d;
      hunt_to    <= hunt_to_d;
      busy       <= (state_d != S_IDLE);
      if (capture) begin
        out_data <= sb_dout;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_inc),
    .count (pkt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Randomized self-checking bench for pkt_rx_ctrl; expected timing is derived
// arithmetically from the sample divider and the two timeouts.
module tb_pkt_rx_ctrl;

  localparam int unsigned SD   = 4;
  localparam int unsigned HT   = 8;
  localparam int unsigned HO   = 64;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [63:0] FRAME0 = 64'hA5A5_3FC0_0000_1234;

  logic          clk;
  logic          rst;
  logic          rx_en;
  logic          sb_rst_n;
  logic          sb_en;
  logic          sb_pkt_rst;
  logic [63:0]   sb_dout;
  logic          sb_pkt_rec;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;
  logic          hunt_to;
  logic          busy;

  int n_checks;
  int n_fail;
  int exp_pkt;
  int exp_drop;

  pkt_rx_ctrl #(
    .SAMPLE_DIV   (SD),
    .HUNT_TIMEOUT (HT),
    .HOLD_TIMEOUT (HO),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .sb_rst_n   (sb_rst_n),
    .sb_en      (sb_en),
    .sb_pkt_rst (sb_pkt_rst),
    .sb_dout    (sb_dout),
    .sb_pkt_rec (sb_pkt_rec),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .hunt_to    (hunt_to),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe and clear must never overlap; the buffer reset mirrors rst.
  always @(negedge clk) begin
    check_val("strobe_excl", sb_en & sb_pkt_rst, 0);
    check_val("sb_rst_n", sb_rst_n, !rst);
  end

  // Entered from IDLE/SETTLE with rx_en=1; HUNT cycle n strobes when n is a multiple of SD.
  task automatic do_hunt_timeout();
    for (int n = 1; n <= int'(SD * HT) + 1; n++) begin
      tick(); sb_pkt_rec = 1'b0; #1;
      check_val("to_hunt_en", sb_en, (n % SD) == 0);
      check_val("to_hunt_flag", hunt_to, 0);
      check_val("to_hunt_busy", busy, 1);
    end
    tick(); #1;
    check_val("to_flag", hunt_to, 1);
    check_val("to_flush", sb_pkt_rst, 1);
    check_val("to_flush_en", sb_en, 0);
    tick(); sb_pkt_rec = 1'b1; #1;
    check_val("to_settle_flag", hunt_to, 0);
    check_val("to_settle_rst", sb_pkt_rst, 0);
  endtask

  // Capture in HUNT cycle r, consumer ready after d HOLD cycles; ends in SETTLE with rx_en=1.
  task automatic do_packet(input int r, input int d, input logic [63:0] frame);
    int k;
    bit xfer;
    for (int n = 1; n < r; n++) begin
      tick(); sb_pkt_rec = 1'b0; out_ready = 1'b0; #1;
      check_val("hunt_en", sb_en, (n % SD) == 0);
      check_val("hunt_ov", out_valid, 0);
      check_val("hunt_busy", busy, 1);
    end
    tick(); sb_pkt_rec = 1'b1; sb_dout = frame; out_ready = 1'b0; #1;
    check_val("cap_en", sb_en, 0);
    check_val("cap_ov", out_valid, 0);
    k = 0;
    xfer = 1'b0;
    do begin
      k++;
      tick();
      sb_pkt_rec = 1'($urandom);
      sb_dout    = {$urandom, $urandom};
      out_ready  = (k > d);
      #1;
      check_val("hold_ov", out_valid, 1);
      check_val("hold_data", out_data, frame);
      check_val("hold_en", sb_en, 0);
      check_val("hold_clr", sb_pkt_rst, 0);
      xfer = (k > d);
    end while (!xfer && k < int'(HO));
    if (xfer) exp_pkt = sat_inc(exp_pkt);
    else      exp_drop = sat_inc(exp_drop);
    tick(); sb_pkt_rec = 1'($urandom); out_ready = 1'($urandom); #1;
    check_val("flush_clr", sb_pkt_rst, 1);
    check_val("flush_ov", out_valid, 0);
    check_val("flush_data", out_data, frame);
    check_val("pkt_cnt", pkt_cnt, exp_pkt);
    check_val("drop_cnt", drop_cnt, exp_drop);
    tick(); sb_pkt_rec = 1'b1; out_ready = 1'b0; #1;
    check_val("settle_clr", sb_pkt_rst, 0);
    check_val("settle_ov", out_valid, 0);
    check_val("settle_busy", busy, 1);
  endtask

  // Drop rx_en in HUNT cycle m; ends in IDLE with rx_en=1 again.
  task automatic do_hunt_abort(input int m);
    for (int n = 1; n <= m; n++) begin
      tick(); sb_pkt_rec = 1'b0; if (n == m) rx_en = 1'b0; #1;
      check_val("abort_hunt_en", sb_en, (n % SD) == 0);
    end
    for (int n = 0; n < 5; n++) begin
      tick(); #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_en", sb_en, 0);
    end
    rx_en = 1'b1;
  endtask

  // Reset while a frame is held: frame discarded, counters back to zero.
  task automatic do_reset_in_hold();
    for (int n = 1; n <= 3; n++) begin
      tick(); sb_pkt_rec = (n == 3); sb_dout = FRAME0; out_ready = 1'b0; #1;
    end
    for (int k = 1; k <= 2; k++) begin
      tick(); sb_pkt_rec = 1'b0; #1;
      check_val("rh_ov", out_valid, 1);
    end
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    exp_pkt  = 0;
    exp_drop = 0;
    check_val("rh_ov0", out_valid, 0);
    check_val("rh_data0", out_data, 0);
    check_val("rh_pkt0", pkt_cnt, exp_pkt);
    check_val("rh_drop0", drop_cnt, exp_drop);
    check_val("rh_busy0", busy, 0);
    check_val("rh_en0", sb_en, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_pkt    = 0;
    exp_drop   = 0;
    rst        = 1'b1;
    rx_en      = 1'b0;
    sb_dout    = '0;
    sb_pkt_rec = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check_val("rst_ov", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_pkt", pkt_cnt, 0);
    check_val("rst_drop", drop_cnt, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_en", sb_en, 0);
    check_val("rst_clr", sb_pkt_rst, 0);
    check_val("rst_hto", hunt_to, 0);
    rst = 1'b0;
    tick(); #1;
    check_val("idle_busy", busy, 0);
    rx_en = 1'b1;

    do_hunt_timeout();
    do_packet(6, 3, FRAME0);
    do_packet(5, 80, {$urandom, $urandom});
    do_packet(int'(SD * HT) + 1, int'(HO) - 1, {$urandom, $urandom});
    do_packet(1, 0, {$urandom, $urandom});
    do_hunt_abort(7);
    do_reset_in_hold();

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 5))
        0:       do_hunt_timeout();
        1:       do_hunt_abort(int'($urandom_range(1, SD * HT)));
        default: do_packet(int'($urandom_range(1, SD * HT + 1)),
                           int'($urandom_range(0, HO + 6)), {$urandom, $urandom});
      endcase
    end
    for (int i = 0; i < CMAX + 2; i++) do_packet(int'($urandom_range(1, 12)), int'(HO), {$urandom, $urandom});
    for (int i = 0; i < CMAX + 2; i++) do_packet(int'($urandom_range(1, 12)), int'($urandom_range(0, 5)), {$urandom, $urandom});

    rx_en = 1'b0;
    tick(); sb_pkt_rec = 1'b0; #1;
    check_val("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pkt_rx_ctrl.md
Name: pkt_rx_ctrl

Overview:
Sequencing controller for the 64-bit serial packet shift buffer.
- Generates the bit-sample strobe (sb_en) and detects the buffer's packet-received flag.
- Captures the 64-bit frame and hands it downstream over a valid/ready handshake.
- Clears the buffer (sb_pkt_rst) after each frame, on a hold timeout, or on a hunt timeout.
- Sits between the shift buffer and the frame consumer; maintains packet/drop counters.

Parameters:
SAMPLE_DIV, 4, clocks per serial bit; sb_en pulses once every SAMPLE_DIV clocks; legal range 3..255
HUNT_TIMEOUT, 1024, sampled bits in HUNT without a packet before a forced buffer clear; 0 disables
HOLD_TIMEOUT, 64, clocks in HOLD waiting for out_ready before the frame is dropped; 0 disables
CNT_W, 16, width of pkt_cnt and drop_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_en  in  1  level; 1 = receive enabled
sb_rst_n  out  1  active-low reset to the shift buffer, equal to ~rst (combinational)
sb_en  out  1  one-clock shift strobe to the buffer
sb_pkt_rst  out  1  one-clock buffer clear
sb_dout  in  64  buffer contents
sb_pkt_rec  in  1  buffer sync-detected flag
out_data  out  64  captured frame, stable while out_valid=1
out_valid  out  1  frame available
out_ready  in  1  consumer accepts; transfer occurs when out_valid and out_ready are both 1 at a rising edge
pkt_cnt  out  CNT_W  frames delivered, saturating
drop_cnt  out  CNT_W  frames dropped on hold timeout, saturating
hunt_to  out  1  one-clock pulse on each hunt timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - sb_en=0, sb_pkt_rst=0, out_valid=0, out_data=0, pkt_cnt=0, drop_cnt=0, hunt_to=0.
  - Divider and timers are cleared.
  - Reset mid-frame discards the frame with no counter update.
- States are IDLE, HUNT, HOLD, FLUSH, SETTLE. The state encoding constants live in the package.
- IDLE:
  - All strobes are 0.
  - If rx_en=1, go to HUNT with the divider at 0.
- HUNT:
  - The divider counts 0..SAMPLE_DIV-1.
  - sb_en=1 for the single cycle where divider==SAMPLE_DIV-1.
  - The bit timer increments on each sb_en; no overflow is possible because the timeout fires first.
  - If sb_pkt_rec=1:
    - Latch out_data<=sb_dout and set out_valid<=1 at that edge.
    - sb_en is forced 0 that cycle.
    - Go to HOLD.
  - The buffer asserts its flag 2 clocks after the sync pattern is shifted in. SAMPLE_DIV>=3 guarantees that no later shift has been applied when the frame is captured.
  - Else, if the bit timer reaches HUNT_TIMEOUT (nonzero):
    - Pulse hunt_to.
    - Go to FLUSH.
  - If rx_en=0 (and sb_pkt_rec=0), go to IDLE at the next edge. Buffer contents are retained.
- HOLD:
  - sb_en=0; the hold timer counts clocks.
  - Transfer (out_ready=1):
    - out_valid<=0.
    - pkt_cnt+1, saturating at all-ones.
    - Go to FLUSH.
  - Otherwise, when the hold timer reaches HOLD_TIMEOUT (nonzero):
    - out_valid<=0.
    - drop_cnt+1, saturating.
    - Go to FLUSH.
  - If transfer and timeout coincide, the transfer wins.
  - rx_en=0 does not abort HOLD.
- FLUSH:
  - sb_pkt_rst=1 for exactly one cycle.
  - Go to SETTLE.
- SETTLE:
  - Lasts one cycle; sb_pkt_rec is ignored because the buffer's flag is stale for one clock after a clear.
  - Go to HUNT if rx_en=1, else IDLE.
  - On entry to HUNT, the divider and bit timer are reset.
- out_data changes only on capture; it holds its value after the transfer.
- sb_en and sb_pkt_rst are never both 1.

Decomposition:
- Package pkt_rx_pkg:
  - State encoding (3-bit localparams).
  - FRAME_W=64.
  - Default SAMPLE_DIV, HUNT_TIMEOUT and HOLD_TIMEOUT.
- Sub-module sat_counter (parameter CNT_W, inputs clk/rst/inc, output count). Instantiated twice, for pkt_cnt and drop_cnt.
- The divider and timers stay inline in the FSM.

Test Plan:
- Reset, then rx_en=1 with SAMPLE_DIV=4 -> sb_en pulses on cycles 4, 8, 12, ... after HUNT entry; busy=1.
- In HUNT, drive sb_dout=64'hA5A5_3FC0_0000_1234 and sb_pkt_rec=1 for one cycle -> the next cycle has out_valid=1 with out_data equal to that value; sb_en stays 0 while out_valid=1.
- Hold out_ready=0 for 3 cycles, then 1 -> the transfer occurs and pkt_cnt=1. Next, sb_pkt_rst=1 for 1 cycle, then one SETTLE cycle in which sb_pkt_rec=1 is ignored, then HUNT.
- out_ready=0 permanently, HOLD_TIMEOUT=64 -> out_valid drops 64 cycles after capture, drop_cnt=1, sb_pkt_rst pulse; force out_ready=1 on the timeout cycle -> pkt_cnt increments instead.
- HUNT_TIMEOUT=8, no sb_pkt_rec -> after the 8th sb_en, hunt_to pulses, then the flush, then HUNT resumes with the divider restarted.
- Assert rst in HOLD -> out_valid=0 and counters=0 next cycle, state IDLE; rx_en=0 in HUNT -> IDLE, sb_en stops.
